mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller for the five-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB boundary, and consumes the EX/MEM control and data fields. It drives a request/acknowledge handshake to a variable-latency data memory and stalls the front of the pipeline while an access is outstanding. It also owns the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles before an access is aborted; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- regwrite_i, memtoreg_i, memread_i, memwrite_i  in  1 each  EX/MEM control fields.
- alu_result_i  in  32  address for loads/stores; result for ALU ops.
- rs2_data_i  in  32  store data.
- rd_addr_i  in  5  destination register.
- stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM this cycle.
- dmem_req_o  out  1  access request, registered.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  32  access address.
- dmem_wdata_o  out  32  store data.
- dmem_rdata_i  in  32  load data, valid with ack.
- dmem_ack_i  in  1  one-cycle completion strobe.
- regwrite_o, memtoreg_o  out  1 each  MEM/WB control.
- read_data_o, alu_result_o  out  32 each  MEM/WB data.
- rd_addr_o  out  5  MEM/WB destination.
- err_o  out  1  timeout abort, aligned with MEM/WB outputs.
- misalign_o  out  1  misaligned access flag, aligned with MEM/WB outputs.

## Operation
- An access is pending when memread_i or memwrite_i is 1. If both are 1, it is a store and read_data_o = 0.
- FSM states:
  - IDLE: with an access present, stall_o = 1, capture addr/wdata/we, go to REQ. With no access, stall_o = 0 and the instruction passes through.
  - REQ: dmem_req_o = 1, with addr/we/wdata held stable; stall_o = 1. On dmem_ack_i, capture dmem_rdata_i into a holding register and go to DONE. On timeout, go to DONE with the error set.
  - DONE: dmem_req_o = 0, stall_o = 0. The MEM/WB register captures the completed instruction. Next state is IDLE.
- MEM/WB update:
  - On every posedge with stall_o = 0, load the EX/MEM fields; read_data_o comes from the holding register (DONE) or is 0 (non-memory op).
  - On a posedge with stall_o = 1, load a bubble: regwrite_o = 0, memtoreg_o = 0, err_o = 0, misalign_o = 0.
- Timeout: a 16-bit counter clears on entry to REQ and increments each REQ cycle without ack. When it equals TIMEOUT_CYCLES, the access aborts. The abort sets err_o = 1 and read_data_o = 0, and forces regwrite_o = 0 for that instruction.
- dmem_ack_i is ignored in IDLE and DONE.
- dmem_addr_o and dmem_wdata_o are 0 whenever dmem_req_o = 0.

## Timing
- Reset: every output is 0 and the state is IDLE. A reset during REQ drops dmem_req_o immediately (async); an outstanding ack after reset is ignored.
- Non-memory op: 1 cycle, no stall.
- Load/store with ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles. Each extra memory wait cycle adds one stall cycle.
- dmem_req_o rises the cycle after the IDLE decision and falls in the cycle after ack.
- Back-to-back accesses: DONE → IDLE, and the next access restarts the sequence. There is at least one non-requesting cycle between requests.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A load/store with alu_result_i[1:0] != 0 never leaves IDLE, issues no request and causes no stall.
  - MEM/WB then captures misalign_o = 1, regwrite_o = 0 and read_data_o = 0.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign_o is tied to 0.
  - The full unmodified address is sent on dmem_addr_o.

## Structure
- Shared package mem_stage_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - the timeout counter width constant (16);
  - the bubble constants for MEM/WB.
- The MEM/WB register is a natural sub-module, reg_memwb: async active-low reset, plus a bubble input that forces control fields to 0.
- The FSM, the timeout counter and the holding register stay in the top level.

## Test plan
- ALU op (regwrite=1, alu_result=0x0000_1234, rd=5): no stall; next cycle regwrite_o=1, alu_result_o=0x1234, rd_addr_o=5.
- Load from 0x100, memory acks after 3 wait cycles with 0xDEAD_BEEF:
  - stall_o high for 5 cycles;
  - read_data_o=0xDEAD_BEEF and memtoreg_o=1 after DONE;
  - bubbles (regwrite_o=0) during the stall.
- Store of rs2=0xA5A5_A5A5 to 0x200, ack after 1 cycle: dmem_we_o=1 with addr/wdata stable during REQ; total latency 3 cycles; regwrite_o=0.
- TIMEOUT_CYCLES=4, no ack: abort after 4 REQ cycles; err_o=1, regwrite_o=0, dmem_req_o drops; a late ack is ignored.
- Assert rst_i low mid-REQ: dmem_req_o, stall_o and all MEM/WB outputs go to 0 immediately; state is IDLE after release.
- With MEM_MISALIGN_TRAP_EN defined, load from 0x102: no request, no stall; misalign_o=1, regwrite_o=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-stage controller
//
// Purpose: state enum for the memory-access FSM, timeout counter width,
//          MEM/WB register layout and the control values loaded on a bubble.
// Ports:   none (package).

package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        err;
    logic        misalign;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  rd_addr;
  } memwb_t;

  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;
  localparam logic BUBBLE_ERR      = 1'b0;
  localparam logic BUBBLE_MISALIGN = 1'b0;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - request/acknowledge bundle to the data memory
//
// Purpose: groups the data-memory handshake of the memory stage.
// Signals: req   - access request (held until ack or abort)
//          we    - 1 = store, 0 = load
//          addr  - access address, 0 while req is low
//          wdata - store data, 0 while req is low
//          rdata - load data, valid with ack
//          ack   - one-cycle completion strobe
// Modports: master (memory-stage controller), slave (data memory).

interface mem_stage_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/reg_memwb.sv
// rtl/reg_memwb.sv - MEM/WB pipeline register with bubble insertion
//
// Purpose: captures the completed memory-stage instruction each clock; when
//          bubble is high the control fields are forced to their bubble values
//          while the data fields still load.
// Ports:   clk_i  - clock
//          rst_i  - asynchronous active-low reset, clears every field
//          bubble - load a bubble this edge
//          d      - next MEM/WB contents
//          q      - registered MEM/WB contents

module reg_memwb
  import mem_stage_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  memwb_t nxt;

  always_comb begin
    nxt = d;
    if (bubble) begin
      nxt.regwrite = BUBBLE_REGWRITE;
      nxt.memtoreg = BUBBLE_MEMTOREG;
      nxt.err      = BUBBLE_ERR;
      nxt.misalign = BUBBLE_MISALIGN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller with variable-latency data memory
//
// Purpose: turns EX/MEM loads/stores into a req/ack access, stalls the front of
//          the pipeline while the access is outstanding, aborts after
//          TIMEOUT_CYCLES request cycles (0 = never) and owns MEM/WB.
// Build option: MEM_MISALIGN_TRAP_EN - misaligned loads/stores are flagged in
//          MEM/WB instead of being sent to memory.
// Ports:   clk_i, rst_i (async active-low)
//          regwrite_i, memtoreg_i, memread_i, memwrite_i, alu_result_i,
//          rs2_data_i, rd_addr_i - EX/MEM fields
//          stall_o - hold PC, IF/ID, ID/EX and EX/MEM
//          dmem    - data-memory handshake (master side)
//          regwrite_o, memtoreg_o, read_data_o, alu_result_o, rd_addr_o,
//          err_o, misalign_o - MEM/WB fields

module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    regwrite_i,
  input  logic                    memtoreg_i,
  input  logic                    memread_i,
  input  logic                    memwrite_i,
  input  logic [31:0]             alu_result_i,
  input  logic [31:0]             rs2_data_i,
  input  logic [4:0]              rd_addr_i,
  output logic                    stall_o,
  mem_stage_ctrl_if.master        dmem,
  output logic                    regwrite_o,
  output logic                    memtoreg_o,
  output logic [31:0]             read_data_o,
  output logic [31:0]             alu_result_o,
  output logic [4:0]              rd_addr_o,
  output logic                    err_o,
  output logic                    misalign_o
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t            state, state_nxt;
  logic              access, misaligned, start, timeout;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic [31:0]       addr_q, wdata_q, hold_q;
  logic              we_q, err_q;
  memwb_t            memwb_d, memwb_q;

  assign access = memread_i | memwrite_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = access & (alu_result_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access (trap build only) is resolved in IDLE without a request.
  assign start   = access & ~misaligned;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // Abort on the REQ cycle whose missing ack would bring the count to the limit,
  // so the request is held for exactly TIMEOUT_CYCLES cycles.
  assign timeout = TO_EN && (state == REQ) && !dmem.ack && (cnt_inc == TO_LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (dmem.ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o              = 1'b0;
    dmem.req             = 1'b0;
    dmem.we              = 1'b0;
    dmem.addr            = '0;
    dmem.wdata           = '0;
    memwb_d.regwrite     = regwrite_i & ~misaligned;
    memwb_d.memtoreg     = memtoreg_i;
    memwb_d.err          = 1'b0;
    memwb_d.misalign     = misaligned;
    memwb_d.read_data    = '0;
    memwb_d.alu_result   = alu_result_i;
    memwb_d.rd_addr      = rd_addr_i;
    case (state)
      IDLE: stall_o = start;
      REQ: begin
        stall_o    = 1'b1;
        dmem.req   = 1'b1;
        dmem.we    = we_q;
        dmem.addr  = addr_q;
        dmem.wdata = wdata_q;
      end
      DONE: begin
        memwb_d.err       = err_q;
        memwb_d.regwrite  = regwrite_i & ~err_q;
        memwb_d.misalign  = 1'b0;
        memwb_d.read_data = (err_q | we_q) ? 32'h0 : hold_q;
      end
      default: ;
    endcase
    // Reset must release the front of the pipeline immediately, even with an
    // access still presented on the EX/MEM fields.
    stall_o = stall_o & rst_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_q  <= alu_result_i;
        wdata_q <= rs2_data_i;
        we_q    <= memwrite_i;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (state == REQ) begin
        if (dmem.ack) begin
          hold_q <= dmem.rdata;
        end else begin
          cnt_q <= cnt_inc;
        end
        if (timeout) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  reg_memwb u_memwb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bubble (stall_o),
    .d      (memwb_d),
    .q      (memwb_q)
  );

  assign regwrite_o   = memwb_q.regwrite;
  assign memtoreg_o   = memwb_q.memtoreg;
  assign read_data_o  = memwb_q.read_data;
  assign alu_result_o = memwb_q.alu_result;
  assign rd_addr_o    = memwb_q.rd_addr;
  assign err_o        = memwb_q.err;
  assign misalign_o   = memwb_q.misalign;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regwrite, memtoreg, memread, memwrite;
  logic [31:0] alu, rs2;
  logic [4:0]  rd;
  logic        stall, regwrite_o, memtoreg_o, err_o, misalign_o;
  logic [31:0] read_data_o, alu_result_o;
  logic [4:0]  rd_addr_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if dmem ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .regwrite_i   (regwrite),
    .memtoreg_i   (memtoreg),
    .memread_i    (memread),
    .memwrite_i   (memwrite),
    .alu_result_i (alu),
    .rs2_data_i   (rs2),
    .rd_addr_i    (rd),
    .stall_o      (stall),
    .dmem         (dmem),
    .regwrite_o   (regwrite_o),
    .memtoreg_o   (memtoreg_o),
    .read_data_o  (read_data_o),
    .alu_result_o (alu_result_o),
    .rd_addr_o    (rd_addr_o),
    .err_o        (err_o),
    .misalign_o   (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one instruction, plays the memory (ack on REQ cycle wait_n+1 when
  // use_ack), and compares stall/request counts and the committed MEM/WB entry
  // against what the instruction should produce.
  task automatic run_op(input string tag, input logic rw, input logic mtr,
                        input logic mr, input logic mw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r,
                        input logic [31:0] rdata_v, input int wait_n,
                        input bit use_ack, input bit late_ack);
    bit memop, mis, tmo, done;
    int exp_stalls, stalls, reqs;
    memop = mr | mw;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = memop && (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    tmo = memop && !mis && (!use_ack || wait_n >= TO);
    exp_stalls = (!memop || mis) ? 0 : (tmo ? 1 + TO : 2 + wait_n);

    regwrite = rw; memtoreg = mtr; memread = mr; memwrite = mw;
    alu = a; rs2 = wd; rd = r;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (dmem.req) begin
        reqs++;
        chk({tag, " addr"}, dmem.addr, a);
        chk({tag, " we"}, 32'(dmem.we), 32'(mw));
        if (mw) chk({tag, " wdata"}, dmem.wdata, wd);
        dmem.ack   = use_ack && (reqs == wait_n + 1);
        dmem.rdata = dmem.ack ? rdata_v : $urandom;
      end else begin
        chk({tag, " idle addr"}, dmem.addr, 32'h0);
        dmem.ack   = late_ack;
        dmem.rdata = $urandom;
      end
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      dmem.ack = 1'b0;
      if (!done) chk({tag, " bubble regwrite"}, 32'(regwrite_o), 32'h0);
    end
    chk({tag, " completes"}, 32'(done), 32'h1);
    chk({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " req cycles"}, 32'(reqs), 32'(exp_stalls > 0 ? exp_stalls - 1 : 0));
    chk({tag, " regwrite_o"}, 32'(regwrite_o), 32'(rw && !tmo && !mis));
    chk({tag, " memtoreg_o"}, 32'(memtoreg_o), 32'(mtr));
    chk({tag, " read_data_o"}, read_data_o, (mr && !mw && !mis && !tmo) ? rdata_v : 32'h0);
    chk({tag, " alu_result_o"}, alu_result_o, a);
    chk({tag, " rd_addr_o"}, 32'(rd_addr_o), 32'(r));
    chk({tag, " err_o"}, 32'(err_o), 32'(tmo));
    chk({tag, " misalign_o"}, 32'(misalign_o), 32'(mis));
  endtask

  initial begin
    int k, w;
    bit ua;
    logic [31:0] a;

    regwrite = 1'b0; memtoreg = 1'b0; memread = 1'b1; memwrite = 1'b0;
    alu = 32'h0; rs2 = 32'h0; rd = 5'd0;
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset req", 32'(dmem.req), 32'h0);
    chk("reset addr", dmem.addr, 32'h0);
    chk("reset wdata", dmem.wdata, 32'h0);
    chk("reset regwrite_o", 32'(regwrite_o), 32'h0);
    chk("reset read_data_o", read_data_o, 32'h0);
    chk("reset alu_result_o", alu_result_o, 32'h0);
    chk("reset err_o", 32'(err_o), 32'h0);
    memread = 1'b0;
    rst = 1'b1;

    run_op("alu", 1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 1, 0);
    run_op("load", 1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 32'hDEAD_BEEF, 3, 1, 0);
    run_op("store", 0, 0, 0, 1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 32'h1111_2222, 0, 1, 0);
    run_op("timeout", 1, 1, 1, 0, 32'h0000_0400, 32'h0, 5'd9, 32'h3333_4444, 0, 0, 1);
    run_op("late wait", 1, 1, 1, 0, 32'h0000_0404, 32'h0, 5'd10, 32'h5555_6666, 4, 1, 0);
    run_op("rd+wr", 1, 0, 1, 1, 32'h0000_0500, 32'h1234_5678, 5'd11, 32'h7777_8888, 1, 1, 0);
    run_op("load 0x102", 1, 1, 1, 0, 32'h0000_0102, 32'h0, 5'd12, 32'h9999_AAAA, 0, 1, 0);

    // Reset in the middle of an outstanding request.
    regwrite = 1'b1; memtoreg = 1'b1; memread = 1'b1; memwrite = 1'b0;
    alu = 32'h0000_0300; rd = 5'd13;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-reset req", 32'(dmem.req), 32'h1);
    rst = 1'b0;
    #1;
    chk("async reset req", 32'(dmem.req), 32'h0);
    chk("async reset stall", 32'(stall), 32'h0);
    chk("async reset addr", dmem.addr, 32'h0);
    chk("async reset regwrite_o", 32'(regwrite_o), 32'h0);
    chk("async reset memtoreg_o", 32'(memtoreg_o), 32'h0);
    chk("async reset alu_result_o", alu_result_o, 32'h0);
    chk("async reset rd_addr_o", 32'(rd_addr_o), 32'h0);
    memread = 1'b0;
    dmem.ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    dmem.ack = 1'b0;
    chk("stray ack after reset", 32'(dmem.req), 32'h0);
    run_op("post-reset load", 1, 1, 1, 0, 32'h0000_0600, 32'h0, 5'd14, 32'hCAFE_F00D, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 3));
      w  = int'($urandom_range(0, 4));
      ua = ($urandom_range(0, 7) != 0);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (k == 1 || k == 3), (k == 2 || k == 3), a, $urandom,
             5'($urandom_range(0, 31)), $urandom, w, ua, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
